// File: rtl/des_f_sequencer_if.sv
// Bus bundle for des_f_sequencer. DES bit n of a W-bit field is vector bit W-n (MSB-first).
// Port l_in exists only when DES_ROUND_XOR_EN is defined.
interface des_f_sequencer_if;
    logic [31:0] r_in;
    logic [47:0] k_in;
`ifdef DES_ROUND_XOR_EN
    logic [31:0] l_in;
`endif
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  sbox_sel;
    logic [5:0]  sbox_in;
    logic [3:0]  sbox_out;
    logic [31:0] f_out;
    logic        out_valid;
    logic        out_ready;

`ifdef DES_ROUND_XOR_EN
    modport slave (
        input  r_in, k_in, l_in, in_valid, sbox_out, out_ready,
        output in_ready, sbox_sel, sbox_in, f_out, out_valid
    );
    modport master (
        output r_in, k_in, l_in, in_valid, sbox_out, out_ready,
        input  in_ready, sbox_sel, sbox_in, f_out, out_valid
    );
`else
    modport slave (
        input  r_in, k_in, in_valid, sbox_out, out_ready,
        output in_ready, sbox_sel, sbox_in, f_out, out_valid
    );
    modport master (
        output r_in, k_in, in_valid, sbox_out, out_ready,
        input  in_ready, sbox_sel, sbox_in, f_out, out_valid
    );
`endif
endinterface

// File: rtl/des_f_sequencer.sv
// DES f-function sequencer: one external S-box lookup per cycle, S1..S8, then P permutation.
// Define DES_ROUND_XOR_EN to add l_in and output L XOR f (the new right half).
module des_f_sequencer (
    input  logic              clk,
    input  logic              rst_n,
    des_f_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    // P table in DES numbering: output bit i+1 takes nibble-word bit P_TBL[i]
    localparam int P_TBL [32] = '{16,  7, 20, 21, 29, 12, 28, 17,
                                   1, 15, 23, 26,  5, 18, 31, 10,
                                   2,  8, 24, 14, 32, 27,  3,  9,
                                  19, 13, 30,  6, 22, 11,  4, 25};

    state_t      r_state;
    logic [2:0]  r_idx;
    logic [47:0] r_mix;
    logic [31:0] r_nib;
    logic [31:0] r_f_out;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [2:0]  r_sbox_sel;
    logic [5:0]  r_sbox_in;
`ifdef DES_ROUND_XOR_EN
    logic [31:0] r_l;
`endif

    logic [47:0] w_e_xor_k;
    logic [5:0]  w_chunk [8];
    logic [31:0] w_nib_full;
    logic [31:0] w_p;
    logic [31:0] w_result;

    genvar gi;
    generate
        // E expansion: chunk j bit m reads R bit 4j+m, wrapping 0->32 and 33->1
        for (gi = 0; gi < 48; gi++) begin : g_expand
            localparam int SRC = ((4 * (gi / 6) + (gi % 6) + 31) % 32) + 1;
            assign w_e_xor_k[47-gi] = bus.r_in[32-SRC] ^ bus.k_in[47-gi];
        end
        for (gi = 0; gi < 8; gi++) begin : g_chunk
            assign w_chunk[gi] = r_mix[47-6*gi -: 6];
            // the nibble being looked up this cycle is taken live from the S-box bank
            assign w_nib_full[31-4*gi -: 4] = (r_idx == 3'(gi)) ? bus.sbox_out
                                                                : r_nib[31-4*gi -: 4];
        end
        for (gi = 0; gi < 32; gi++) begin : g_perm
            assign w_p[31-gi] = w_nib_full[32-P_TBL[gi]];
        end
    endgenerate

`ifdef DES_ROUND_XOR_EN
    assign w_result = r_l ^ w_p;
`else
    assign w_result = w_p;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= 3'd0;
            r_mix       <= 48'd0;
            r_nib       <= 32'd0;
            r_f_out     <= 32'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_sbox_sel  <= 3'd0;
            r_sbox_in   <= 6'd0;
`ifdef DES_ROUND_XOR_EN
            r_l         <= 32'd0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (bus.in_valid && r_in_ready) begin
                        r_mix      <= w_e_xor_k;
                        r_idx      <= 3'd0;
                        r_nib      <= 32'd0;
                        r_sbox_sel <= 3'd0;
                        r_sbox_in  <= w_e_xor_k[47:42];
                        r_in_ready <= 1'b0;
                        r_state    <= SUB;
`ifdef DES_ROUND_XOR_EN
                        r_l        <= bus.l_in;
`endif
                    end
                end
                SUB: begin
                    r_nib <= w_nib_full;
                    if (r_idx == 3'd7) begin
                        // idx parks at 7; it only restarts from 0 on the next acceptance
                        r_f_out     <= w_result;
                        r_out_valid <= 1'b1;
                        r_sbox_sel  <= 3'd0;
                        r_sbox_in   <= 6'd0;
                        r_state     <= DONE;
                    end else begin
                        r_idx      <= r_idx + 3'd1;
                        r_sbox_sel <= r_idx + 3'd1;
                        r_sbox_in  <= w_chunk[r_idx + 3'd1];
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.f_out     = r_f_out;
    assign bus.sbox_sel  = r_sbox_sel;
    assign bus.sbox_in   = r_sbox_in;
endmodule
